// File: rtl/leading_count_unit_pkg.sv
// Shared definitions for the leading-count unit: FSM state encoding and count-width helper.
// Build option LEADING_ONES_EN (see leading_count_unit.sv) does not affect this package.
package lead_count_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_BUSY = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    // Count must represent 0..W inclusive, hence one bit more than log2(W).
    function automatic int count_width(input int data_width);
        return $clog2(data_width) + 1;
    endfunction

endpackage

// File: rtl/leading_count_unit_if.sv
// Operand/result valid-ready bundle for the leading-count unit.
// in_op exists only when LEADING_ONES_EN is defined.
interface leading_count_unit_if
    import lead_count_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) ();
    localparam int CW = count_width(DATA_WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
`ifdef LEADING_ONES_EN
    logic                  in_op;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [CW-1:0]         out_count;
    logic [DATA_WIDTH-1:0] out_norm;

`ifdef LEADING_ONES_EN
    modport master (output in_valid, in_data, in_op, out_ready,
                    input  in_ready, out_valid, out_count, out_norm);
    modport slave  (input  in_valid, in_data, in_op, out_ready,
                    output in_ready, out_valid, out_count, out_norm);
`else
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_count, out_norm);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_count, out_norm);
`endif

endinterface

// File: rtl/leading_count_unit_group_lz_enc.sv
// Combinational STEP-bit priority encoder: leading zeros of one group, plus an all-zero flag.
// lz reads STEP when the group is all zero.
module group_lz_enc #(
    parameter int STEP = 4,
    parameter int CW   = 6
) (
    input  logic [STEP-1:0] grp_i,
    output logic [CW-1:0]   lz_o,
    output logic            all_zero_o
);

    logic found;

    always_comb begin
        lz_o  = '0;
        found = 1'b0;
        for (int i = STEP - 1; i >= 0; i--) begin
            if (!found) begin
                if (grp_i[i]) found = 1'b1;
                else          lz_o  = lz_o + CW'(1);
            end
        end
        all_zero_o = !found;
    end

endmodule

// File: rtl/leading_count_unit.sv
// Multi-cycle leading-zero (optionally leading-one via LEADING_ONES_EN) counter and normalizer.
// Busy min(k+1, W/STEP) cycles for k leading zero groups; result held until out_ready, accepts only in IDLE.
module leading_count_unit
    import lead_count_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STEP       = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    leading_count_unit_if.slave  bus
);

    localparam int CW = count_width(DATA_WIDTH);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] search;
    logic [CW-1:0]         count_step;
    logic [CW-1:0]         lz;
    logic                  all_zero;

    group_lz_enc #(.STEP(STEP), .CW(CW)) u_enc (
        .grp_i      (work_q[DATA_WIDTH-1 -: STEP]),
        .lz_o       (lz),
        .all_zero_o (all_zero)
    );

    // Ones are counted by inverting at accept, so the datapath only ever searches zeros.
`ifdef LEADING_ONES_EN
    assign search = bus.in_op ? ~bus.in_data : bus.in_data;
`else
    assign search = bus.in_data;
`endif

    assign count_step = count_q + CW'(STEP);

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        case (state_q)
            STATE_IDLE: begin
                if (bus.in_valid) begin
                    work_d  = search;
                    count_d = '0;
                    state_d = STATE_BUSY;
                end
            end
            STATE_BUSY: begin
                if (all_zero) begin
                    work_d  = work_q << STEP;
                    count_d = count_step;
                    if (count_step == CW'(DATA_WIDTH)) state_d = STATE_DONE;
                end else begin
                    work_d  = work_q << lz;
                    count_d = count_q + lz;
                    state_d = STATE_DONE;
                end
            end
            STATE_DONE: begin
                if (bus.out_ready) state_d = STATE_IDLE;
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= STATE_IDLE;
            work_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = (state_q == STATE_IDLE);
    assign bus.out_valid = (state_q == STATE_DONE);
    assign bus.out_count = count_q;
    assign bus.out_norm  = work_q;

endmodule
